// File: rtl/cluster_frame_formatter_pkg.sv
// Common constants and types for the cluster frame formatter:
// cluster layout, link word layout, FIFO sizing and the output word helpers.
package cluster_frame_formatter_pkg;

    localparam int MXCLSTBITS     = 14;
    localparam int MXADRBITS      = 11;
    localparam int MXCNTBITS      = 3;
    localparam int MXCLUSTERS     = 8;
    localparam int MXOUTBITS      = 56;
    localparam int MXBXNBITS      = 12;
    localparam int MXNBITS        = 4;
    localparam int MXDROPBITS     = 8;
    localparam int SLOTBITS       = 3;
    localparam int SLOTS_PER_WORD = MXOUTBITS / MXCLSTBITS;
    localparam int FIFO_DEPTH     = 4;
    localparam int FIFO_ADRBITS   = 2;

    localparam logic [MXADRBITS-1:0]  INVALID_ADR  = 11'h7FF;
    localparam logic [MXCLSTBITS-1:0] FILL_CLUSTER = {{MXCNTBITS{1'b0}}, INVALID_ADR};

    // Slot k of a set sits at bits [14k+13:14k], matching the link word layout
    typedef logic [MXCLUSTERS-1:0][MXCLSTBITS-1:0] cluster_set_t;

    typedef struct packed {
        logic [MXBXNBITS-1:0] bxn;
        logic [MXNBITS-1:0]   n;
        cluster_set_t         clusters;
    } bx_entry_t;

    typedef struct packed {
        logic                 valid;
        logic                 sof;
        logic                 eof;
        logic [MXBXNBITS-1:0] bxn;
        logic [MXOUTBITS-1:0] data;
    } frame_word_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WORD0 = 2'd1,
        ST_WORD1 = 2'd2
    } frame_state_t;

    function automatic logic isValidCluster(input logic [MXCLSTBITS-1:0] c);
        return c[MXADRBITS-1:0] != INVALID_ADR;
    endfunction

    // Slots 0..3 of a crossing; it is also the last word when four or fewer clusters are valid
    function automatic frame_word_t firstWord(input bx_entry_t e);
        frame_word_t w;
        w.valid = 1'b1;
        w.sof   = 1'b1;
        w.eof   = (e.n <= MXNBITS'(SLOTS_PER_WORD));
        w.bxn   = e.bxn;
        w.data  = e.clusters[SLOTS_PER_WORD-1:0];
        return w;
    endfunction

    // Slots 4..7 of a crossing; always closes the crossing
    function automatic frame_word_t secondWord(input bx_entry_t e);
        frame_word_t w;
        w.valid = 1'b1;
        w.sof   = 1'b0;
        w.eof   = 1'b1;
        w.bxn   = e.bxn;
        w.data  = e.clusters[MXCLUSTERS-1:SLOTS_PER_WORD];
        return w;
    endfunction

endpackage

// File: rtl/cluster_frame_formatter_compactor.sv
// Combinational compaction of one crossing: valid clusters are packed into the
// lowest slots in their original priority order, the rest get the fill word.
module cluster_compactor
    import cluster_frame_formatter_pkg::*;
(
    input  cluster_set_t       i_clusters,
    output cluster_set_t       o_clusters,
    output logic [MXNBITS-1:0] o_count
);

    cluster_set_t       w_compacted;
    logic [MXNBITS-1:0] w_count;

    // Walk the slots in priority order, appending each valid cluster behind those already kept
    always_comb begin
        w_compacted = {MXCLUSTERS{FILL_CLUSTER}};
        w_count     = '0;
        for (int i = 0; i < MXCLUSTERS; i++) begin
            if (isValidCluster(i_clusters[i])) begin
                w_compacted[w_count[SLOTBITS-1:0]] = i_clusters[i];
                w_count = w_count + MXNBITS'(1);
            end
        end
    end

    assign o_clusters = w_compacted;
    assign o_count    = w_count;

endmodule

// File: rtl/cluster_frame_formatter.sv
// Captures and compacts the eight clusters of each crossing, buffers non-empty
// crossings in a small FIFO and streams them as one or two 56-bit link words.
module cluster_frame_formatter
    import cluster_frame_formatter_pkg::*;
(
    input  logic                  clock4x,
    input  logic                  global_reset,
    input  logic                  clusters_valid,
    input  logic [MXCLSTBITS-1:0] cluster0,
    input  logic [MXCLSTBITS-1:0] cluster1,
    input  logic [MXCLSTBITS-1:0] cluster2,
    input  logic [MXCLSTBITS-1:0] cluster3,
    input  logic [MXCLSTBITS-1:0] cluster4,
    input  logic [MXCLSTBITS-1:0] cluster5,
    input  logic [MXCLSTBITS-1:0] cluster6,
    input  logic [MXCLSTBITS-1:0] cluster7,
    input  logic [MXBXNBITS-1:0]  bxn,
    input  logic                  frame_ready,
    output logic [MXOUTBITS-1:0]  frame_data,
    output logic                  frame_valid,
    output logic                  frame_sof,
    output logic                  frame_eof,
    output logic [MXBXNBITS-1:0]  frame_bxn,
    output logic                  overflow,
    output logic [MXDROPBITS-1:0] drop_cnt
);

    cluster_set_t              w_rawClusters;
    cluster_set_t              w_compClusters;
    logic [MXNBITS-1:0]        w_compCount;

    logic                      r_capValid;
    bx_entry_t                 r_capEntry;

    bx_entry_t                 r_fifo [FIFO_DEPTH];
    logic [FIFO_ADRBITS:0]     r_wrPtr;
    logic [FIFO_ADRBITS:0]     r_rdPtr;
    logic [FIFO_ADRBITS:0]     w_occupancy;
    logic [FIFO_ADRBITS-1:0]   w_nextIdx;
    logic                      w_empty;
    logic                      w_full;
    logic                      w_wrReq;
    logic                      w_wrEn;
    logic                      w_drop;
    logic                      w_moreAfterPop;
    bx_entry_t                 w_head;
    bx_entry_t                 w_next;

    logic                      r_overflow;
    logic [MXDROPBITS-1:0]     r_dropCnt;

    frame_state_t              r_state;
    frame_state_t              w_stateNext;
    frame_word_t               r_word;
    frame_word_t               w_wordNext;
    logic                      w_accept;
    logic                      w_pop;
    logic                      w_finishBx;

    assign w_rawClusters = {cluster7, cluster6, cluster5, cluster4,
                            cluster3, cluster2, cluster1, cluster0};

    cluster_compactor u_compactor (
        .i_clusters (w_rawClusters),
        .o_clusters (w_compClusters),
        .o_count    (w_compCount)
    );

    // Capture stage: register the compacted crossing together with its bxn and valid count
    always_ff @(posedge clock4x or posedge global_reset) begin
        if (global_reset) begin
            r_capValid <= 1'b0;
            r_capEntry <= '0;
        end else begin
            r_capValid <= clusters_valid;
            if (clusters_valid) begin
                r_capEntry <= {bxn, w_compCount, w_compClusters};
            end
        end
    end

    // A pop in the same cycle frees the head slot, so a full FIFO still accepts the write
    assign w_empty        = (r_wrPtr == r_rdPtr);
    assign w_full         = (r_wrPtr[FIFO_ADRBITS] != r_rdPtr[FIFO_ADRBITS]) &&
                            (r_wrPtr[FIFO_ADRBITS-1:0] == r_rdPtr[FIFO_ADRBITS-1:0]);
    assign w_wrReq        = r_capValid && (r_capEntry.n != '0);
    assign w_wrEn         = w_wrReq && (!w_full || w_pop);
    assign w_drop         = w_wrReq && w_full && !w_pop;
    assign w_occupancy    = r_wrPtr - r_rdPtr;
    assign w_moreAfterPop = (w_occupancy > (FIFO_ADRBITS+1)'(1));
    assign w_nextIdx      = r_rdPtr[FIFO_ADRBITS-1:0] + FIFO_ADRBITS'(1);
    assign w_head         = r_fifo[r_rdPtr[FIFO_ADRBITS-1:0]];
    assign w_next         = r_fifo[w_nextIdx];

    // FIFO pointers advance on accepted writes and on head pops
    always_ff @(posedge clock4x or posedge global_reset) begin
        if (global_reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_wrEn) r_wrPtr <= r_wrPtr + (FIFO_ADRBITS+1)'(1);
            if (w_pop)  r_rdPtr <= r_rdPtr + (FIFO_ADRBITS+1)'(1);
        end
    end

    // FIFO storage is pure data; the pointers alone decide what is live
    always_ff @(posedge clock4x) begin
        if (w_wrEn) r_fifo[r_wrPtr[FIFO_ADRBITS-1:0]] <= r_capEntry;
    end

    // Sticky overflow flag and saturating count of crossings lost to a full FIFO
    always_ff @(posedge clock4x or posedge global_reset) begin
        if (global_reset) begin
            r_overflow <= 1'b0;
            r_dropCnt  <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_dropCnt != {MXDROPBITS{1'b1}}) r_dropCnt <= r_dropCnt + MXDROPBITS'(1);
        end
    end

    assign w_accept = r_word.valid && frame_ready;

    // Output state and the registered link word
    always_ff @(posedge clock4x or posedge global_reset) begin
        if (global_reset) begin
            r_state <= ST_IDLE;
            r_word  <= '0;
        end else begin
            r_state <= w_stateNext;
            r_word  <= w_wordNext;
        end
    end

    // Next state, head pop and next word; the word holds by default so an unaccepted word stays stable
    always_comb begin
        w_stateNext = r_state;
        w_wordNext  = r_word;
        w_pop       = 1'b0;
        w_finishBx  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_stateNext = ST_WORD0;
                    w_wordNext  = firstWord(w_head);
                end
            end
            ST_WORD0: begin
                if (w_accept) begin
                    if (w_head.n > MXNBITS'(SLOTS_PER_WORD)) begin
                        w_stateNext = ST_WORD1;
                        w_wordNext  = secondWord(w_head);
                    end else begin
                        w_finishBx = 1'b1;
                    end
                end
            end
            ST_WORD1: begin
                if (w_accept) w_finishBx = 1'b1;
            end
            default: begin
                w_stateNext = ST_IDLE;
                w_wordNext  = '0;
            end
        endcase
        if (w_finishBx) begin
            w_pop = 1'b1;
            if (w_moreAfterPop) begin
                w_stateNext = ST_WORD0;
                w_wordNext  = firstWord(w_next);
            end else begin
                w_stateNext = ST_IDLE;
                w_wordNext  = '0;
            end
        end
    end

    assign frame_data  = r_word.data;
    assign frame_valid = r_word.valid;
    assign frame_sof   = r_word.sof;
    assign frame_eof   = r_word.eof;
    assign frame_bxn   = r_word.bxn;
    assign overflow    = r_overflow;
    assign drop_cnt    = r_dropCnt;

endmodule

// File: tb/tb_cluster_frame_formatter.sv
// Testbench for cluster_frame_formatter: directed scenarios plus a randomized
// phase, with a queue-based reference model and an independent output monitor.
module tb_cluster_frame_formatter;

    typedef struct packed {
        logic [55:0] data;
        logic        sof;
        logic        eof;
        logic [11:0] bxn;
    } word_t;

    logic        clock4x;
    logic        global_reset;
    logic        clusters_valid;
    logic [13:0] clIn [8];
    logic [11:0] bxn;
    logic        frame_ready;
    logic [55:0] frame_data;
    logic        frame_valid;
    logic        frame_sof;
    logic        frame_eof;
    logic [11:0] frame_bxn;
    logic        overflow;
    logic [7:0]  drop_cnt;

    word_t       expQ [$];
    int          tests = 0;
    int          fails = 0;
    int          expDrop = 0;
    int          pushedBx = 0;
    int          doneBx = 0;
    bit          randReady = 0;

    cluster_frame_formatter dut (
        .clock4x        (clock4x),
        .global_reset   (global_reset),
        .clusters_valid (clusters_valid),
        .cluster0       (clIn[0]),
        .cluster1       (clIn[1]),
        .cluster2       (clIn[2]),
        .cluster3       (clIn[3]),
        .cluster4       (clIn[4]),
        .cluster5       (clIn[5]),
        .cluster6       (clIn[6]),
        .cluster7       (clIn[7]),
        .bxn            (bxn),
        .frame_ready    (frame_ready),
        .frame_data     (frame_data),
        .frame_valid    (frame_valid),
        .frame_sof      (frame_sof),
        .frame_eof      (frame_eof),
        .frame_bxn      (frame_bxn),
        .overflow       (overflow),
        .drop_cnt       (drop_cnt)
    );

    // Free-running clock
    initial begin
        clock4x = 1'b0;
        forever #5 clock4x = ~clock4x;
    end

    // Hard time limit so the bench can never hang
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock4x);
        #1;
        if (randReady) frame_ready = ($urandom_range(0, 3) != 0);
    endtask

    function automatic int countValid();
        int n = 0;
        for (int i = 0; i < 8; i++) if (clIn[i][10:0] != 11'h7FF) n++;
        return n;
    endfunction

    // Reference model: gather the valid clusters in order, then cut them into 4-slot words
    task automatic pushExpected(input logic [11:0] bx);
        logic [13:0] kept [$];
        word_t       w;
        int          nWords;
        int          idx;
        for (int i = 0; i < 8; i++) if (clIn[i][10:0] != 11'h7FF) kept.push_back(clIn[i]);
        nWords = (kept.size() > 4) ? 2 : 1;
        for (int wd = 0; wd < nWords; wd++) begin
            w.data = '0;
            for (int k = 0; k < 4; k++) begin
                idx = wd * 4 + k;
                w.data[k*14 +: 14] = (idx < kept.size()) ? kept[idx] : 14'h07FF;
            end
            w.sof = (wd == 0);
            w.eof = (wd == nWords - 1);
            w.bxn = bx;
            expQ.push_back(w);
        end
    endtask

    // One-cycle strobe of the current clIn pattern; 'stored' says whether the FIFO has room for it
    task automatic applyStimulus(input logic [11:0] bx, input bit stored);
        bxn = bx;
        clusters_valid = 1'b1;
        if (countValid() != 0) begin
            if (stored) begin
                pushExpected(bx);
                pushedBx++;
            end else begin
                expDrop = (expDrop >= 255) ? 255 : expDrop + 1;
            end
        end
        tick();
        clusters_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int guard = 0;
        while ((expQ.size() != 0) && (guard < 500)) begin
            tick();
            guard++;
        end
        if (guard >= 500) checkOutput("drainTimeout", 128'(expQ.size()), 128'(0));
        repeat (3) tick();
    endtask

    task automatic setSingle(input logic [13:0] c);
        for (int i = 0; i < 8; i++) clIn[i] = 14'h07FF;
        clIn[0] = c;
    endtask

    task automatic randomClusters(input int pattern);
        for (int i = 0; i < 8; i++) begin
            clIn[i][13:11] = 3'($urandom_range(0, 7));
            if (pattern == 0)      clIn[i][10:0] = 11'($urandom_range(0, 2046));
            else if (pattern == 1) clIn[i][10:0] = 11'h7FF;
            else if (pattern == 2) clIn[i][10:0] = (i < 4) ? 11'($urandom_range(0, 2046)) : 11'h7FF;
            else                   clIn[i][10:0] = ($urandom_range(0, 1) != 0) ? 11'($urandom_range(0, 2046)) : 11'h7FF;
        end
    endtask

    // Monitor: compares every accepted word with the scoreboard and checks held words stay stable
    initial begin
        word_t heldW;
        word_t curW;
        word_t expW;
        bit    held = 0;
        forever begin
            @(negedge clock4x);
            if (global_reset) begin
                held = 0;
                continue;
            end
            curW = {frame_data, frame_sof, frame_eof, frame_bxn};
            if (frame_valid) begin
                if (held) checkOutput("holdStable", 128'(curW), 128'(heldW));
                if (frame_ready) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpectedWord", 128'(curW), 128'(0));
                    end else begin
                        expW = expQ.pop_front();
                        checkOutput("wordData", 128'(frame_data), 128'(expW.data));
                        checkOutput("wordFlags", 128'({frame_sof, frame_eof, frame_bxn}),
                                    128'({expW.sof, expW.eof, expW.bxn}));
                        if (expW.eof) doneBx++;
                    end
                    held = 0;
                end else begin
                    held  = 1;
                    heldW = curW;
                end
            end else begin
                if (held) checkOutput("validDropped", 128'(frame_valid), 128'(1));
                held = 0;
            end
        end
    end

    // Stimulus sequence
    initial begin
        int guard;
        global_reset   = 1'b1;
        clusters_valid = 1'b0;
        frame_ready    = 1'b0;
        bxn            = '0;
        for (int i = 0; i < 8; i++) clIn[i] = 14'h07FF;
        repeat (2) @(posedge clock4x);
        #1;
        checkOutput("rstValid", 128'(frame_valid), 128'(0));
        checkOutput("rstData", 128'(frame_data), 128'(0));
        checkOutput("rstFlags", 128'({frame_sof, frame_eof, frame_bxn}), 128'(0));
        checkOutput("rstOverflow", 128'(overflow), 128'(0));
        checkOutput("rstDropCnt", 128'(drop_cnt), 128'(0));
        global_reset = 1'b0;
        frame_ready  = 1'b1;
        tick();

        // Single cluster, three-cycle latency, single word frame
        setSingle(14'h1005);
        applyStimulus(12'h123, 1);
        tick();
        checkOutput("t1NotYet", 128'(frame_valid), 128'(0));
        tick();
        checkOutput("t1Latency", 128'(frame_valid), 128'(1));
        checkOutput("t1SofEof", 128'({frame_sof, frame_eof}), 128'(2'b11));
        checkOutput("t1Bxn", 128'(frame_bxn), 128'(12'h123));
        checkOutput("t1Data", 128'(frame_data),
                    128'({14'h07FF, 14'h07FF, 14'h07FF, 14'h1005}));
        waitDrain();

        // Six clusters with holes at slots 1 and 4, two back-to-back words
        clIn[0] = 14'h0800; clIn[1] = 14'h07FF; clIn[2] = 14'h080A; clIn[3] = 14'h0814;
        clIn[4] = 14'h07FF; clIn[5] = 14'h081E; clIn[6] = 14'h0828; clIn[7] = 14'h0832;
        applyStimulus(12'h0A5, 1);
        tick();
        tick();
        checkOutput("t2Word0", 128'(frame_data),
                    128'({14'h081E, 14'h0814, 14'h080A, 14'h0800}));
        checkOutput("t2Flags0", 128'({frame_valid, frame_sof, frame_eof}), 128'(3'b110));
        tick();
        checkOutput("t2Word1", 128'(frame_data),
                    128'({14'h07FF, 14'h07FF, 14'h0832, 14'h0828}));
        checkOutput("t2Flags1", 128'({frame_valid, frame_sof, frame_eof}), 128'(3'b101));
        waitDrain();

        // Empty crossing produces nothing
        for (int i = 0; i < 8; i++) clIn[i] = 14'h07FF;
        applyStimulus(12'h0EE, 1);
        repeat (5) tick();
        checkOutput("t3NoValid", 128'(frame_valid), 128'(0));
        checkOutput("t3DropCnt", 128'(drop_cnt), 128'(0));

        // Six strobes into a stalled link: four stored, two dropped
        frame_ready = 1'b0;
        for (int s = 0; s < 6; s++) begin
            setSingle({3'(s), 11'(16 + s)});
            applyStimulus(12'(12'h200 + s), s < 4);
        end
        repeat (3) tick();
        checkOutput("t4Overflow", 128'(overflow), 128'(1));
        checkOutput("t4DropCnt", 128'(drop_cnt), 128'(expDrop));
        frame_ready = 1'b1;
        waitDrain();

        // Full FIFO: head eof accepted in the same cycle a new entry is written
        frame_ready = 1'b0;
        for (int s = 0; s < 4; s++) begin
            setSingle({3'd3, 11'(100 + s)});
            applyStimulus(12'(12'h300 + s), 1);
        end
        repeat (3) tick();
        setSingle({3'd5, 11'd200});
        applyStimulus(12'h304, 1);
        frame_ready = 1'b1;
        repeat (3) tick();
        checkOutput("t5DropCnt", 128'(drop_cnt), 128'(expDrop));
        waitDrain();

        // Randomized traffic with a random link stall pattern, kept below FIFO capacity
        randReady = 1;
        for (int b = 0; b < 40; b++) begin
            guard = 0;
            while (((pushedBx - doneBx) >= 3) && (guard < 200)) begin
                tick();
                guard++;
            end
            if (guard >= 200) checkOutput("flowTimeout", 128'(pushedBx - doneBx), 128'(0));
            randomClusters((b % 10 == 0) ? 0 : (b % 10 == 5) ? 1 : (b % 10 == 7) ? 2 : 3);
            applyStimulus(12'($urandom), 1);
            repeat ($urandom_range(0, 2)) tick();
        end
        randReady   = 0;
        frame_ready = 1'b1;
        waitDrain();
        checkOutput("rndDropCnt", 128'(drop_cnt), 128'(expDrop));
        checkOutput("rndOverflow", 128'(overflow), 128'(1));

        // Drop counter saturation under a long stall
        frame_ready = 1'b0;
        for (int s = 0; s < 100; s++) begin
            setSingle({3'd1, 11'(s)});
            applyStimulus(12'(12'h400 + s), s < 4);
        end
        repeat (3) tick();
        checkOutput("satMidCount", 128'(drop_cnt), 128'(expDrop));
        for (int s = 0; s < 200; s++) begin
            setSingle({3'd2, 11'(s)});
            applyStimulus(12'(12'h500 + s), 0);
        end
        repeat (3) tick();
        checkOutput("satCount", 128'(drop_cnt), 128'(expDrop));
        frame_ready = 1'b1;
        waitDrain();

        // Asynchronous reset in the middle of the first word of a full crossing
        frame_ready = 1'b0;
        for (int i = 0; i < 8; i++) clIn[i] = {3'd4, 11'(i * 3)};
        applyStimulus(12'h777, 1);
        repeat (3) tick();
        checkOutput("t6Holding", 128'({frame_valid, frame_sof, frame_eof}), 128'(3'b110));
        #2;
        global_reset = 1'b1;
        #1;
        checkOutput("t6RstValid", 128'(frame_valid), 128'(0));
        checkOutput("t6RstData", 128'(frame_data), 128'(0));
        checkOutput("t6RstFlags", 128'({frame_sof, frame_eof, frame_bxn}), 128'(0));
        checkOutput("t6RstOverflow", 128'(overflow), 128'(0));
        expQ.delete();
        pushedBx = doneBx;
        expDrop  = 0;
        tick();
        global_reset = 1'b0;
        frame_ready  = 1'b1;
        repeat (10) tick();
        checkOutput("t6NoStale", 128'(frame_valid), 128'(0));
        checkOutput("t6Overflow", 128'(overflow), 128'(0));
        checkOutput("t6DropCnt", 128'(drop_cnt), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
